skip_pulse_meter: RTL and testbench
===================================

// Module: skip_pulse_meter
// PURPOSE
//  Downstream of the skip-clock ring. Samples the ring's skipped clock (sCLK) and position-0 marker (B0) in the mCLK domain.
//  Per ring revolution (B0 rise to B0 rise) it counts sCLK rising edges and mCLK cycles.
//  It then publishes both with a one-cycle VALID strobe. Used to check MASK/rSEL programming on hardware and in simulation.
// PARAMETERS
//  CW   8   width of pulse counter / PCOUNT (saturating)
//  PW   32  width of period counter / PERIOD (saturating)
// PORTS
//  mCLK    in   1   system clock; the only clock
//  RST     in   1   synchronous, active-high reset
//  E       in   1   measurement enable
//  sCLK    in   1   skipped clock from ring (asynchronous/slow)
//  B0      in   1   ring position-0 marker (asynchronous/slow)
//  PCOUNT  out  CW  sCLK rising edges in last complete revolution
//  PERIOD  out  PW  mCLK cycles between the last two B0 edges
//  VALID   out  1   one-cycle strobe: PCOUNT/PERIOD just updated
//  OVF     out  1   sticky: a counter saturated in the last revolution
// BEHAVIOUR
//  - Reset: PCOUNT=0, PERIOD=0, VALID=0, OVF=0, state=IDLE, counters=0, edge-detect history=0.
//    No spurious edge is reported on the first cycle after reset.
//  - Edge detect: rise = sample & ~prev_sample, one strobe per input rising edge.
//    Latency from input edge to rise strobe is 3 mCLK cycles with the sync stage, 1 without.
//  - FSM:
//    IDLE: wait. On B0 rise with E=1 go to MEAS. pcnt = sCLK rise in same cycle ? 1 : 0. per=1.
//    MEAS, no B0 rise: per += 1 (saturates at all-ones). On sCLK rise pcnt += 1 (saturates at all-ones).
//      Any saturation sets an internal ovf flag.
//    MEAS, B0 rise: PCOUNT<=pcnt, PERIOD<=per, OVF<=ovf, VALID<=1 for 1 cycle. Stay in MEAS.
//      Restart counters exactly as on IDLE->MEAS; clear ovf.
//  - Simultaneous sCLK rise and B0 rise: that pulse belongs to the NEW revolution, not the latched one.
//  - PERIOD is the number of cycles between consecutive detected B0 rise strobes. Edges 100 cycles apart give 100.
//  - E=0 in any state: next state IDLE, counters cleared, no VALID.
//    PCOUNT/PERIOD/OVF hold their last values. Re-enabling waits for a fresh B0 rise; the partial revolution is discarded.
//  - RST mid-revolution: everything returns to reset values next cycle; no VALID is emitted.
//  - Outputs are registered; VALID never stays high 2 consecutive cycles.
//    Needs at least 2 cycles between B0 edges, which the slow ring guarantees.
// CONFIGURATION
//  SKIP_METER_SYNC_EN defined: sCLK and B0 each pass a 2-FF synchronizer before edge detect (latency 3).
//    Use this for real hardware.
//  SKIP_METER_SYNC_EN undefined: inputs assumed already mCLK-synchronous (ring clocked by a tick in the mCLK domain).
//    Edge detect is applied directly (latency 1). Counted values are identical in both builds; only latency differs.
// STRUCTURE
//  - Package skip_pkg: state enum {IDLE, MEAS}, default widths SKIP_CW=8, SKIP_PW=32.
//    The same package holds the ring LEN=16 constant shared with the skip-ring block.
//  - Sub-module skip_edge_sync (sync + rising-edge strobe, honours SKIP_METER_SYNC_EN), instantiated for sCLK and B0.
//  - FSM, counters and output registers live in this module.
// TESTING
//  1. Ring LEN=16, rSEL=0x0001, MASK=0xCCCC, sCLK period 20 cycles, E=1.
//     Second and later VALID: PCOUNT=8, PERIOD=320, OVF=0.
//  2. B0 and sCLK rising in the same cycle at every revolution start (8 pulses/rev).
//     PCOUNT=8, not 7 or 9; first pulse counted in the new revolution.
//  3. CW=4, 20 sCLK pulses per revolution -> PCOUNT=15, OVF=1.
//     Next revolution with 8 pulses -> PCOUNT=8, OVF=0.
//  4. Drop E for 5 cycles mid-revolution, then raise it.
//     No VALID until two further B0 rises; outputs hold their old values meanwhile.
//  5. Assert RST 50 cycles into a revolution -> all outputs 0 next cycle.
//     First VALID only after two post-reset B0 rises.
//  6. Run 1 with and without SKIP_METER_SYNC_EN: identical PCOUNT/PERIOD, VALID 2 cycles later with sync.

Source files
------------

// File: rtl/skip_pkg.sv
// Shared definitions for the skip-clock ring and its pulse meter: FSM state
// encoding, default counter widths and the ring length.
package skip_pkg;

  localparam int SKIP_CW = 8;
  localparam int SKIP_PW = 32;
  localparam int LEN     = 16;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/skip_pulse_meter_if.sv
// Measurement bus of skip_pulse_meter: ring inputs and enable from the
// controlling side, published counts back to it.
interface skip_pulse_meter_if
  import skip_pkg::*;
#(
  parameter int CW = SKIP_CW,
  parameter int PW = SKIP_PW
);

  logic          E;
  logic          sCLK;
  logic          B0;
  logic [CW-1:0] PCOUNT;
  logic [PW-1:0] PERIOD;
  logic          VALID;
  logic          OVF;

  modport master (output E, sCLK, B0, input PCOUNT, PERIOD, VALID, OVF);
  modport slave  (input E, sCLK, B0, output PCOUNT, PERIOD, VALID, OVF);

endinterface

// File: rtl/skip_edge_sync.sv
// Rising-edge strobe for one ring signal in the mCLK domain. With
// SKIP_METER_SYNC_EN defined a 2-FF synchronizer precedes the edge detector.
module skip_edge_sync (
  input  logic mCLK,
  input  logic RST,
  input  logic din,
  output logic rise
);

  logic samp_in;
  logic samp;
  logic prev;

`ifdef SKIP_METER_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge mCLK) begin
    if (RST) sync <= '0;
    else     sync <= {sync[0], din};
  end

  assign samp_in = sync[1];
`else
  assign samp_in = din;
`endif

  // NOTE: non-blocking assignments let samp and prev update together, so
  // prev always holds the previous cycle's sample regardless of statement order.
  always_ff @(posedge mCLK) begin
    if (RST) begin
      samp <= 1'b0;
      prev <= 1'b0;
    end else begin
      samp <= samp_in;
      prev <= samp;
    end
  end

  assign rise = samp & ~prev;

endmodule

// File: rtl/skip_pulse_meter.sv
// Counts sCLK rising edges and mCLK cycles per ring revolution (B0 rise to
// B0 rise) and publishes them with a VALID strobe. Build option: SKIP_METER_SYNC_EN.
module skip_pulse_meter
  import skip_pkg::*;
#(
  parameter int CW = SKIP_CW,
  parameter int PW = SKIP_PW
) (
  input logic             mCLK,
  input logic             RST,
  skip_pulse_meter_if.slave bus
);

  localparam logic [CW-1:0] PCNT_ONE = CW'(1);
  localparam logic [CW-1:0] PCNT_MAX = '1;
  localparam logic [PW-1:0] PER_ONE  = PW'(1);
  localparam logic [PW-1:0] PER_MAX  = '1;

  logic s_rise;
  logic b_rise;

  skip_edge_sync u_sclk_edge (.mCLK(mCLK), .RST(RST), .din(bus.sCLK), .rise(s_rise));
  skip_edge_sync u_b0_edge   (.mCLK(mCLK), .RST(RST), .din(bus.B0),   .rise(b_rise));

  state_t        state,    state_n;
  logic [CW-1:0] pcnt,     pcnt_n;
  logic [PW-1:0] per,      per_n;
  logic          ovf,      ovf_n;
  logic [CW-1:0] pcount_q, pcount_n;
  logic [PW-1:0] period_q, period_n;
  logic          ovf_q,    ovf_out_n;
  logic          valid_q,  valid_n;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    pcnt_n    = pcnt;
    per_n     = per;
    ovf_n     = ovf;
    pcount_n  = pcount_q;
    period_n  = period_q;
    ovf_out_n = ovf_q;
    valid_n   = 1'b0;

    if (!bus.E) begin
      state_n = IDLE;
      pcnt_n  = '0;
      per_n   = '0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (b_rise) begin
            state_n = MEAS;
            pcnt_n  = s_rise ? PCNT_ONE : '0;
            per_n   = PER_ONE;
            ovf_n   = 1'b0;
          end
        end
        MEAS: begin
          if (b_rise) begin
            pcount_n  = pcnt;
            period_n  = per;
            ovf_out_n = ovf;
            valid_n   = 1'b1;
            // A pulse coinciding with B0 opens the new revolution.
            pcnt_n    = s_rise ? PCNT_ONE : '0;
            per_n     = PER_ONE;
            ovf_n     = 1'b0;
          end else begin
            if (per == PER_MAX) ovf_n = 1'b1;
            else                per_n = per + PER_ONE;
            if (s_rise) begin
              if (pcnt == PCNT_MAX) ovf_n  = 1'b1;
              else                  pcnt_n = pcnt + PCNT_ONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge mCLK) begin
    if (RST) begin
      state    <= IDLE;
      pcnt     <= '0;
      per      <= '0;
      ovf      <= 1'b0;
      pcount_q <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      per      <= per_n;
      ovf      <= ovf_n;
      pcount_q <= pcount_n;
      period_q <= period_n;
      ovf_q    <= ovf_out_n;
      valid_q  <= valid_n;
    end
  end

  assign bus.PCOUNT = pcount_q;
  assign bus.PERIOD = period_q;
  assign bus.OVF    = ovf_q;
  assign bus.VALID  = valid_q;

endmodule

// File: tb/tb_skip_pulse_meter.sv
// Bench for skip_pulse_meter: 8-bit and 4-bit pulse-counter instances share one
// input waveform; directed revolution table, enable/reset sequences, random revolutions.
module tb_skip_pulse_meter;
  import skip_pkg::*;

  localparam int MAXC = 16000;
  localparam int SPER = 20;
  localparam int REV  = LEN * SPER;
  localparam logic [15:0] MASK = 16'hCCCC;
`ifdef SKIP_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic mclk = 1'b0;
  logic rst;
  always #5 mclk = ~mclk;

  skip_pulse_meter_if #(.CW(8), .PW(32)) if8 ();
  skip_pulse_meter_if #(.CW(4), .PW(32)) if4 ();

  skip_pulse_meter #(.CW(8), .PW(32)) dut8 (.mCLK(mclk), .RST(rst), .bus(if8.slave));
  skip_pulse_meter #(.CW(4), .PW(32)) dut4 (.mCLK(mclk), .RST(rst), .bus(if4.slave));

  typedef struct {
    int len; int n; int sp; int off; int use_mask;
    int pc8; int pc4; int ovf8; int ovf4; int per;
  } vec_t;

  typedef struct { int pc8; int pc4; int ovf8; int ovf4; int per; } pub_t;

  bit   in_s [MAXC];
  bit   in_b [MAXC];
  bit   in_e [MAXC];
  bit   in_r [MAXC];
  int   ncyc;
  int   rst_cyc;
  int   n_cmp;
  int   n_bad;
  pub_t got[$];
  pub_t exp_o;
  bit   exp_valid;
  bit   started;
  int   start_edge;
  vec_t tbl [13];
  pub_t dir_exp [17];

  task automatic check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic add_cycle(input bit b, input bit s, input bit e, input bit r);
    if (ncyc >= MAXC) begin
      $display("FAIL schedule: stimulus exceeds %0d cycles", MAXC);
      $fatal(1, "schedule overflow");
    end
    in_b[ncyc] = b; in_s[ncyc] = s; in_e[ncyc] = e; in_r[ncyc] = r;
    ncyc++;
  endtask

  task automatic add_quiet(input int k, input bit e, input bit r);
    for (int c = 0; c < k; c++) add_cycle(1'b0, 1'b0, e, r);
  endtask

  // One revolution: B0 high at its start, n sCLK pulses (or the MASK pattern).
  task automatic add_row(input int len, input int n, input int sp, input int off,
                         input int use_mask, input int edrop_at, input int edrop_len,
                         input int rst_at);
    int bh;
    bit s;
    bh = (len >= 40) ? 10 : 1;
    if (rst_at >= 0) rst_cyc = ncyc + rst_at;
    for (int c = 0; c < len; c++) begin
      s = 1'b0;
      if (use_mask != 0) begin
        s = MASK[(c / SPER) % LEN] && ((c % SPER) < SPER / 2);
      end else begin
        for (int k = 0; k < n; k++)
          if (c >= off + k * sp && c < off + k * sp + sp / 2) s = 1'b1;
      end
      add_cycle(c < bh, s, !(c >= edrop_at && c < edrop_at + edrop_len), c == rst_at);
    end
  endtask

  // Input rising edge in cycle j.
  function automatic bit rise_of(input bit is_b0, input int j);
    if (j < 1 || j >= ncyc) return 1'b0;
    return is_b0 ? (in_b[j] && !in_b[j-1]) : (in_s[j] && !in_s[j-1]);
  endfunction

  // Expected outputs after clock edge i: a revolution's counts are the sCLK
  // rises and cycles in the interval between its two B0 rises.
  task automatic model_step(input int i);
    int n;
    exp_valid = 1'b0;
    if (in_r[i-1]) begin
      exp_o   = '{0, 0, 0, 0, 0};
      started = 1'b0;
    end else if (!in_e[i-1]) begin
      started = 1'b0;
    end else if (rise_of(1'b1, i - 1 - LAT)) begin
      if (started) begin
        n = 0;
        for (int t = start_edge; t < i; t++) n += int'(rise_of(1'b0, t - 1 - LAT));
        exp_o.pc8  = (n > 255) ? 255 : n;
        exp_o.pc4  = (n > 15) ? 15 : n;
        exp_o.ovf8 = int'(n > 255);
        exp_o.ovf4 = int'(n > 15);
        exp_o.per  = i - start_edge;
        exp_valid  = 1'b1;
      end
      started    = 1'b1;
      start_edge = i;
    end
  endtask

  initial begin
    int len, n, sp, off, edrop;
    pub_t a;
    n_cmp = 0; n_bad = 0; ncyc = 0; rst_cyc = -10;
    started = 1'b0; start_edge = 0; exp_o = '{0, 0, 0, 0, 0};
    rst = 1'b1;
    if8.E = 1'b0; if8.sCLK = 1'b0; if8.B0 = 1'b0;
    if4.E = 1'b0; if4.sCLK = 1'b0; if4.B0 = 1'b0;

    //          len  n  sp off msk   pc8 pc4 o8 o4 per
    tbl[0]  = '{REV, 0,  0, 0, 1,    8,  8, 0, 0, REV};
    tbl[1]  = '{REV, 0,  0, 0, 1,    8,  8, 0, 0, REV};
    tbl[2]  = '{160, 8, 20, 0, 0,    8,  8, 0, 0, 160};
    tbl[3]  = '{160, 8, 20, 0, 0,    8,  8, 0, 0, 160};
    tbl[4]  = '{200, 20, 8, 2, 0,   20, 15, 0, 1, 200};
    tbl[5]  = '{200, 8, 20, 5, 0,    8,  8, 0, 0, 200};
    tbl[6]  = '{50,  0,  0, 0, 0,    0,  0, 0, 0, 50};
    tbl[7]  = '{100, 16, 6, 1, 0,   16, 15, 0, 1, 100};
    tbl[8]  = '{100, 14, 6, 1, 0,   14, 14, 0, 0, 100};
    tbl[9]  = '{2,   0,  0, 0, 0,    0,  0, 0, 0, 2};
    tbl[10] = '{2,   0,  0, 0, 0,    0,  0, 0, 0, 2};
    tbl[11] = '{3,   1,  2, 0, 0,    1,  1, 0, 0, 3};
    tbl[12] = '{10,  0,  0, 0, 0,    0,  0, 0, 0, 0};
    for (int k = 0; k < 12; k++)
      dir_exp[k] = '{tbl[k].pc8, tbl[k].pc4, tbl[k].ovf8, tbl[k].ovf4, tbl[k].per};
    dir_exp[12] = '{4, 4, 0, 0, 200};
    dir_exp[13] = '{7, 7, 0, 0, 200};
    dir_exp[14] = '{5, 5, 0, 0, 200};
    dir_exp[15] = '{3, 3, 0, 0, 150};
    dir_exp[16] = '{9, 9, 0, 0, 150};

    add_quiet(6, 1'b1, 1'b1);
    add_quiet(6, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++)
      add_row(tbl[k].len, tbl[k].n, tbl[k].sp, tbl[k].off, tbl[k].use_mask, -1, 0, -1);
    add_quiet(10, 1'b0, 1'b0);

    // Enable dropped mid-revolution for 5 cycles.
    add_row(200, 4, 40, 15, 0, -1, 0, -1);
    add_row(200, 6, 25, 12, 0, 100, 5, -1);
    add_row(200, 7, 25, 12, 0, -1, 0, -1);
    add_row(10, 0, 0, 0, 0, -1, 0, -1);
    add_quiet(10, 1'b0, 1'b0);

    // Reset 50 cycles into a revolution.
    add_row(200, 5, 30, 20, 0, -1, 0, -1);
    add_row(200, 3, 30, 60, 0, -1, 0, 50);
    add_row(150, 3, 30, 20, 0, -1, 0, -1);
    add_row(150, 9, 14, 12, 0, -1, 0, -1);
    add_row(10, 0, 0, 0, 0, -1, 0, -1);
    add_quiet(10, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      len = int'($urandom_range(300, 60));
      n   = int'($urandom_range(24, 0));
      if (n > (len - 12) / 2) n = (len - 12) / 2;
      if (n == 15) n = 14;
      sp    = (n > 0) ? (len - 12) / n : 0;
      off   = ($urandom_range(3, 0) == 0) ? 0 : 11;
      edrop = ($urandom_range(5, 0) == 0) ? len / 2 : -1;
      add_row(len, n, sp, off, 0, edrop, 3, -1);
    end
    add_row(10, 0, 0, 0, 0, -1, 0, -1);
    add_quiet(10, 1'b0, 1'b0);

    for (int i = 0; i < ncyc; i++) begin
      @(posedge mclk);
      #1;
      rst = in_r[i];
      if8.E = in_e[i]; if8.sCLK = in_s[i]; if8.B0 = in_b[i];
      if4.E = in_e[i]; if4.sCLK = in_s[i]; if4.B0 = in_b[i];
      if (i >= 1) model_step(i);
      @(negedge mclk);
      if (i >= 1) begin
        a = '{int'(if8.PCOUNT), int'(if4.PCOUNT), int'(if8.OVF), int'(if4.OVF), int'(if8.PERIOD)};
        check("cycle", (if8.VALID == exp_valid) && (if4.VALID == exp_valid) &&
              (a == exp_o) && (int'(if4.PERIOD) == exp_o.per),
              $sformatf("cyc %0d got v%0b/%0b pc %0d/%0d per %0d/%0d ovf %0d/%0d, want v%0b pc %0d/%0d per %0d ovf %0d/%0d",
                        i, if8.VALID, if4.VALID, a.pc8, a.pc4, a.per, int'(if4.PERIOD), a.ovf8, a.ovf4,
                        exp_valid, exp_o.pc8, exp_o.pc4, exp_o.per, exp_o.ovf8, exp_o.ovf4));
        if (i == rst_cyc + 1)
          check("reset_clear", if8.PCOUNT == 8'd0 && if8.PERIOD == 32'd0 && !if8.VALID && !if8.OVF &&
                if4.PCOUNT == 4'd0 && if4.PERIOD == 32'd0 && !if4.VALID && !if4.OVF,
                $sformatf("got pc %0d per %0d v %0b ovf %0b, want all 0",
                          if8.PCOUNT, if8.PERIOD, if8.VALID, if8.OVF));
        if (if8.VALID) got.push_back(a);
      end
    end

    for (int k = 0; k < 17; k++) begin
      if (k < got.size())
        check($sformatf("pub%0d", k), got[k] == dir_exp[k],
              $sformatf("got pc %0d/%0d ovf %0d/%0d per %0d, want pc %0d/%0d ovf %0d/%0d per %0d",
                        got[k].pc8, got[k].pc4, got[k].ovf8, got[k].ovf4, got[k].per,
                        dir_exp[k].pc8, dir_exp[k].pc4, dir_exp[k].ovf8, dir_exp[k].ovf4, dir_exp[k].per));
      else
        check($sformatf("pub%0d", k), 1'b0,
              $sformatf("got only %0d VALID strobes, want at least %0d", got.size(), k + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
